// File: rtl/rgb_to_ycbcr_pkg.sv
// rgb_to_ycbcr_pkg: constants and types shared by the skin-tone colour-space blocks.
// The BT.601 coefficients are scaled by 256. Downstream alignment logic uses LATENCY
// to match the delay of the conversion pipeline.
package rgb_to_ycbcr_pkg;

   localparam int LATENCY = 3;
   localparam int COUNT_W = 24;
   localparam int SUM_W   = 18;

   localparam int Y_R  = 66;
   localparam int Y_G  = 129;
   localparam int Y_B  = 25;
   localparam int CB_R = -38;
   localparam int CB_G = -74;
   localparam int CB_B = 112;
   localparam int CR_R = 112;
   localparam int CR_G = -94;
   localparam int CR_B = -18;

   localparam int ROUND    = 128;
   localparam int Y_OFFSET = 16;
   localparam int C_OFFSET = 128;

   localparam int CLAMP_LO   = 16;
   localparam int Y_CLAMP_HI = 235;
   localparam int C_CLAMP_HI = 240;
   localparam int FULL_LO    = 0;
   localparam int FULL_HI    = 255;

   localparam logic [7:0] Y_RESET = 8'd16;
   localparam logic [7:0] C_RESET = 8'd128;

   // Signed intermediate wide enough for the largest weighted sum of 8-bit samples
   typedef logic signed [SUM_W-1:0] sum_t;

   typedef struct packed {
      logic valid;
      logic sof;
      logic eol;
   } side_t;

   // Saturate a signed intermediate into an 8-bit result between lo and hi
   function automatic logic [7:0] clamp_u8(input sum_t v, input sum_t lo, input sum_t hi);
      logic [7:0] res;
      if (v < lo) begin
         res = lo[7:0];
      end else if (v > hi) begin
         res = hi[7:0];
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/rgb_to_ycbcr_ycc_channel.sv
// ycc_channel: one output channel of the RGB to YCbCr conversion.
// Stage 1 forms the three products. Stage 2 sums them with the rounding constant.
// Stage 3 applies the floor shift, adds the offset, and clamps into the output register.
module ycc_channel
   import rgb_to_ycbcr_pkg::*;
#(
   parameter int         COEF_R      = 0,
   parameter int         COEF_G      = 0,
   parameter int         COEF_B      = 0,
   parameter int         OFFSET      = 0,
   parameter int         LIMIT_LO    = 0,
   parameter int         LIMIT_HI    = 255,
   parameter logic [7:0] RESET_VALUE = 8'd0
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] r_value,
   input  logic [7:0] g_value,
   input  logic [7:0] b_value,
   output logic [7:0] ch_value
);

   localparam sum_t K_R      = sum_t'(COEF_R);
   localparam sum_t K_G      = sum_t'(COEF_G);
   localparam sum_t K_B      = sum_t'(COEF_B);
   localparam sum_t ROUND_S  = sum_t'(ROUND);
   localparam sum_t OFFSET_S = sum_t'(OFFSET);
   localparam sum_t LO_S     = sum_t'(LIMIT_LO);
   localparam sum_t HI_S     = sum_t'(LIMIT_HI);

   sum_t       prod_r_q, prod_r_d;
   sum_t       prod_g_q, prod_g_d;
   sum_t       prod_b_q, prod_b_d;
   sum_t       sum_q, sum_d;
   sum_t       shifted;
   sum_t       biased;
   logic [7:0] ch_q, ch_d;

   // Stage 1: weight each zero-extended sample by its signed coefficient
   always_comb begin
      prod_r_d = $signed({10'd0, r_value}) * K_R;
      prod_g_d = $signed({10'd0, g_value}) * K_G;
      prod_b_d = $signed({10'd0, b_value}) * K_B;
   end

   // Stage 2: accumulate the products together with the rounding constant
   always_comb begin
      sum_d = prod_r_q + prod_g_q + prod_b_q + ROUND_S;
   end

   // Stage 3: floor-divide by 256, add the channel offset, and saturate
   always_comb begin
      shifted = sum_q >>> 8;
      biased  = shifted + OFFSET_S;
      ch_d    = clamp_u8(biased, LO_S, HI_S);
   end

   // Pipeline registers. Reset leaves the output at the channel's black level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_r_q <= '0;
         prod_g_q <= '0;
         prod_b_q <= '0;
         sum_q    <= '0;
         ch_q     <= RESET_VALUE;
      end else begin
         prod_r_q <= prod_r_d;
         prod_g_q <= prod_g_d;
         prod_b_q <= prod_b_d;
         sum_q    <= sum_d;
         ch_q     <= ch_d;
      end
   end

   assign ch_value = ch_q;

endmodule

// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: BT.601 RGB to YCbCr converter for the skin-tone detector front end.
// Three ycc_channel pipelines carry the data. Valid, sof and eol travel in a shift
// register of the same depth. A pixel counter restarts at each start of frame.
module rgb_to_ycbcr
   import rgb_to_ycbcr_pkg::*;
#(
   parameter bit CLAMP_EN = 1'b1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         r_value,
   input  logic [7:0]         g_value,
   input  logic [7:0]         b_value,
   input  logic               datain_valid,
   input  logic               sof_in,
   input  logic               eol_in,
   output logic [7:0]         y_value,
   output logic [7:0]         cb_value,
   output logic [7:0]         cr_value,
   output logic               dataout_valid,
   output logic               sof_out,
   output logic               eol_out,
   output logic [COUNT_W-1:0] pixel_count
);

   localparam int Y_LO = CLAMP_EN ? CLAMP_LO   : FULL_LO;
   localparam int Y_HI = CLAMP_EN ? Y_CLAMP_HI : FULL_HI;
   localparam int C_LO = CLAMP_EN ? CLAMP_LO   : FULL_LO;
   localparam int C_HI = CLAMP_EN ? C_CLAMP_HI : FULL_HI;

   side_t [LATENCY-1:0] side_q, side_d;
   logic  [COUNT_W-1:0] pixel_count_q, pixel_count_d;

   ycc_channel #(
      .COEF_R(Y_R), .COEF_G(Y_G), .COEF_B(Y_B), .OFFSET(Y_OFFSET),
      .LIMIT_LO(Y_LO), .LIMIT_HI(Y_HI), .RESET_VALUE(Y_RESET)
   ) u_luma (
      .clk(clk), .rst(rst),
      .r_value(r_value), .g_value(g_value), .b_value(b_value),
      .ch_value(y_value)
   );

   ycc_channel #(
      .COEF_R(CB_R), .COEF_G(CB_G), .COEF_B(CB_B), .OFFSET(C_OFFSET),
      .LIMIT_LO(C_LO), .LIMIT_HI(C_HI), .RESET_VALUE(C_RESET)
   ) u_cb (
      .clk(clk), .rst(rst),
      .r_value(r_value), .g_value(g_value), .b_value(b_value),
      .ch_value(cb_value)
   );

   ycc_channel #(
      .COEF_R(CR_R), .COEF_G(CR_G), .COEF_B(CR_B), .OFFSET(C_OFFSET),
      .LIMIT_LO(C_LO), .LIMIT_HI(C_HI), .RESET_VALUE(C_RESET)
   ) u_cr (
      .clk(clk), .rst(rst),
      .r_value(r_value), .g_value(g_value), .b_value(b_value),
      .ch_value(cr_value)
   );

   // Sideband shift register. sof and eol are only meaningful together with valid.
   always_comb begin
      side_d       = side_q;
      side_d[0]    = '{valid: datain_valid,
                       sof:   datain_valid & sof_in,
                       eol:   datain_valid & eol_in};
      for (int i = 1; i < LATENCY; i++) begin
         side_d[i] = side_q[i-1];
      end
   end

   // Pixel counter. It loads from the stage feeding the output, so the count lines up with the sample.
   always_comb begin
      pixel_count_d = pixel_count_q;
      if (side_q[LATENCY-2].valid) begin
         if (side_q[LATENCY-2].sof) begin
            pixel_count_d = COUNT_W'(1);
         end else begin
            pixel_count_d = pixel_count_q + COUNT_W'(1);
         end
      end
   end

   // Sideband and counter registers. Reset discards every sample in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         side_q        <= '0;
         pixel_count_q <= '0;
      end else begin
         side_q        <= side_d;
         pixel_count_q <= pixel_count_d;
      end
   end

   assign dataout_valid = side_q[LATENCY-1].valid;
   assign sof_out       = side_q[LATENCY-1].sof;
   assign eol_out       = side_q[LATENCY-1].eol;
   assign pixel_count   = pixel_count_q;

endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: drives a clamped and an unclamped converter from the same stimulus.
// Every output sample is compared against a BT.601 arithmetic model that sees the
// sample three cycles after it was applied.
module tb_rgb_to_ycbcr;

   localparam int LAT = 3;

   typedef struct packed {
      logic       valid;
      logic       sof;
      logic       eol;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pix_t;

   typedef struct packed {
      logic        v;
      logic        sof;
      logic        eol;
      logic [7:0]  y;
      logic [7:0]  cb;
      logic [7:0]  cr;
      logic [23:0] cnt;
      logic        vn;
      logic        sofn;
      logic        eoln;
      logic [7:0]  yn;
      logic [7:0]  cbn;
      logic [7:0]  crn;
      logic [23:0] cntn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  r_value, g_value, b_value;
   logic        datain_valid, sof_in, eol_in;

   logic [7:0]  y_c, cb_c, cr_c;
   logic        vld_c, sof_c, eol_c;
   logic [23:0] cnt_c;
   logic [7:0]  y_n, cb_n, cr_n;
   logic        vld_n, sof_n, eol_n;
   logic [23:0] cnt_n;

   int          vectors     = 0;
   int          miscompares = 0;
   logic [23:0] model_cnt   = '0;
   exp_t        hq[$];
   pix_t        idle        = '0;

   always #5 clk = ~clk;

   rgb_to_ycbcr #(.CLAMP_EN(1'b1)) dut (
      .clk(clk), .rst(rst),
      .r_value(r_value), .g_value(g_value), .b_value(b_value),
      .datain_valid(datain_valid), .sof_in(sof_in), .eol_in(eol_in),
      .y_value(y_c), .cb_value(cb_c), .cr_value(cr_c),
      .dataout_valid(vld_c), .sof_out(sof_c), .eol_out(eol_c),
      .pixel_count(cnt_c)
   );

   rgb_to_ycbcr #(.CLAMP_EN(1'b0)) dut_nc (
      .clk(clk), .rst(rst),
      .r_value(r_value), .g_value(g_value), .b_value(b_value),
      .datain_valid(datain_valid), .sof_in(sof_in), .eol_in(eol_in),
      .y_value(y_n), .cb_value(cb_n), .cr_value(cr_n),
      .dataout_valid(vld_n), .sof_out(sof_n), .eol_out(eol_n),
      .pixel_count(cnt_n)
   );

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   // Reference model: BT.601 formulas on plain integers plus the frame pixel count
   task automatic predict(input pix_t p, output exp_t e);
      int r, g, b, yf, cbf, crf;
      e   = '0;
      r   = int'(p.r);
      g   = int'(p.g);
      b   = int'(p.b);
      yf  = ((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16;
      cbf = ((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128;
      crf = ((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128;
      if (p.valid) begin
         model_cnt = p.sof ? 24'd1 : model_cnt + 24'd1;
         e.v    = 1'b1;
         e.sof  = p.sof;
         e.eol  = p.eol;
         e.y    = 8'(clampi(yf, 16, 235));
         e.cb   = 8'(clampi(cbf, 16, 240));
         e.cr   = 8'(clampi(crf, 16, 240));
         e.vn   = 1'b1;
         e.sofn = p.sof;
         e.eoln = p.eol;
         e.yn   = 8'(clampi(yf, 0, 255));
         e.cbn  = 8'(clampi(cbf, 0, 255));
         e.crn  = 8'(clampi(crf, 0, 255));
      end
      e.cnt  = model_cnt;
      e.cntn = model_cnt;
   endtask

   function automatic exp_t observe();
      exp_t o;
      o      = '0;
      o.v    = vld_c;
      o.sof  = sof_c;
      o.eol  = eol_c;
      o.cnt  = cnt_c;
      if (vld_c) begin
         o.y  = y_c;
         o.cb = cb_c;
         o.cr = cr_c;
      end
      o.vn   = vld_n;
      o.sofn = sof_n;
      o.eoln = eol_n;
      o.cntn = cnt_n;
      if (vld_n) begin
         o.yn  = y_n;
         o.cbn = cb_n;
         o.crn = cr_n;
      end
      return o;
   endfunction

   // Called at a negedge. Sample the outputs, hand back the expectation that is due now,
   // apply the next pixel, and advance to the following negedge.
   task automatic step(input pix_t p, output exp_t e, output exp_t o);
      exp_t ne;
      o            = observe();
      e            = hq.pop_front();
      r_value      = p.r;
      g_value      = p.g;
      b_value      = p.b;
      datain_valid = p.valid;
      sof_in       = p.sof;
      eol_in       = p.eol;
      predict(p, ne);
      hq.push_back(ne);
      @(negedge clk);
   endtask

   task automatic restart_model();
      hq.delete();
      model_cnt = '0;
      for (int i = 0; i < LAT; i++) hq.push_back('0);
   endtask

   function automatic pix_t rand_pix(input logic valid, input logic sof, input logic eol);
      pix_t p;
      p.valid = valid;
      p.sof   = sof;
      p.eol   = eol;
      p.r     = 8'($urandom);
      p.g     = 8'($urandom);
      p.b     = 8'($urandom);
      return p;
   endfunction

   task automatic test_reset();
      r_value = '0; g_value = '0; b_value = '0;
      datain_valid = 1'b0; sof_in = 1'b0; eol_in = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({vld_c, sof_c, eol_c, y_c, cb_c, cr_c, cnt_c} !== {3'b000, 8'd16, 8'd128, 8'd128, 24'd0}) begin
         miscompares++;
         $display("[TB] FAIL reset_clamped: got v=%b sof=%b eol=%b y=%0d cb=%0d cr=%0d cnt=%0d, expected 0 0 0 16 128 128 0",
                  vld_c, sof_c, eol_c, y_c, cb_c, cr_c, cnt_c);
      end
      vectors++;
      if ({vld_n, sof_n, eol_n, y_n, cb_n, cr_n, cnt_n} !== {3'b000, 8'd16, 8'd128, 8'd128, 24'd0}) begin
         miscompares++;
         $display("[TB] FAIL reset_full_range: got v=%b sof=%b eol=%b y=%0d cb=%0d cr=%0d cnt=%0d, expected 0 0 0 16 128 128 0",
                  vld_n, sof_n, eol_n, y_n, cb_n, cr_n, cnt_n);
      end
      rst = 1'b0;
      restart_model();
   endtask

   task automatic test_known_colours();
      pix_t       tbl[4];
      logic [7:0] ky[4], kcb[4], kcr[4];
      exp_t       e, o;
      tbl[0] = '{valid: 1'b1, sof: 1'b0, eol: 1'b0, r: 8'd0,   g: 8'd0,   b: 8'd0};
      tbl[1] = '{valid: 1'b1, sof: 1'b0, eol: 1'b0, r: 8'd255, g: 8'd255, b: 8'd255};
      tbl[2] = '{valid: 1'b1, sof: 1'b0, eol: 1'b0, r: 8'd255, g: 8'd0,   b: 8'd0};
      tbl[3] = '{valid: 1'b1, sof: 1'b0, eol: 1'b0, r: 8'd0,   g: 8'd0,   b: 8'd255};
      ky  = '{8'd16,  8'd235, 8'd82,  8'd41};
      kcb = '{8'd128, 8'd128, 8'd90,  8'd240};
      kcr = '{8'd128, 8'd128, 8'd240, 8'd110};
      for (int i = 0; i < 4 + LAT; i++) begin
         step((i < 4) ? tbl[i] : idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL known_model step %0d: got %h, expected %h", i, o, e);
         end
         if (i >= LAT) begin
            vectors++;
            if ({o.v, o.y, o.cb, o.cr, o.yn, o.cbn, o.crn} !==
                {1'b1, ky[i-LAT], kcb[i-LAT], kcr[i-LAT], ky[i-LAT], kcb[i-LAT], kcr[i-LAT]}) begin
               miscompares++;
               $display("[TB] FAIL known_colour %0d: got v=%b y=%0d cb=%0d cr=%0d (full %0d %0d %0d), expected y=%0d cb=%0d cr=%0d",
                        i - LAT, o.v, o.y, o.cb, o.cr, o.yn, o.cbn, o.crn, ky[i-LAT], kcb[i-LAT], kcr[i-LAT]);
            end
         end
      end
   endtask

   task automatic test_sideband();
      logic [4:0]  pv   = 5'b01101;
      logic [4:0]  ps   = 5'b00001;
      logic [4:0]  pe   = 5'b01000;
      logic [23:0] kcnt[5];
      exp_t        e, o;
      kcnt = '{24'd1, 24'd1, 24'd2, 24'd3, 24'd3};
      for (int i = 0; i < 5 + LAT; i++) begin
         step((i < 5) ? rand_pix(pv[i], ps[i], pe[i]) : idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL sideband_model step %0d: got %h, expected %h", i, o, e);
         end
         if (i >= LAT) begin
            vectors++;
            if ({o.v, o.sof, o.eol, o.cnt} !== {pv[i-LAT], ps[i-LAT], pe[i-LAT], kcnt[i-LAT]}) begin
               miscompares++;
               $display("[TB] FAIL sideband_pattern %0d: got v=%b sof=%b eol=%b cnt=%0d, expected v=%b sof=%b eol=%b cnt=%0d",
                        i - LAT, o.v, o.sof, o.eol, o.cnt, pv[i-LAT], ps[i-LAT], pe[i-LAT], kcnt[i-LAT]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] pe = 4'b1001;
      exp_t       e, o;
      for (int i = 0; i < 4 + LAT; i++) begin
         step((i < 4) ? rand_pix(1'b1, 1'b1, pe[i]) : idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL back_to_back_model step %0d: got %h, expected %h", i, o, e);
         end
         if (i >= LAT) begin
            vectors++;
            if ({o.v, o.sof, o.eol, o.cnt} !== {1'b1, 1'b1, pe[i-LAT], 24'd1}) begin
               miscompares++;
               $display("[TB] FAIL back_to_back_sof %0d: got v=%b sof=%b eol=%b cnt=%0d, expected v=1 sof=1 eol=%b cnt=1",
                        i - LAT, o.v, o.sof, o.eol, o.cnt, pe[i-LAT]);
            end
         end
      end
   endtask

   task automatic test_midstream_reset();
      logic [5:0] pv = 6'b110111;
      exp_t       e, o;
      for (int i = 0; i < 6; i++) begin
         step(rand_pix(pv[i], 1'b0, 1'b0), e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL pre_reset step %0d: got %h, expected %h", i, o, e);
         end
      end
      rst          = 1'b1;
      datain_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if ({vld_c, sof_c, eol_c, y_c, cb_c, cr_c, cnt_c, vld_n, cnt_n} !==
          {3'b000, 8'd16, 8'd128, 8'd128, 24'd0, 1'b0, 24'd0}) begin
         miscompares++;
         $display("[TB] FAIL midstream_reset: got v=%b sof=%b eol=%b y=%0d cb=%0d cr=%0d cnt=%0d nc_v=%b nc_cnt=%0d, expected reset values",
                  vld_c, sof_c, eol_c, y_c, cb_c, cr_c, cnt_c, vld_n, cnt_n);
      end
      @(negedge clk);
      rst = 1'b0;
      restart_model();
      for (int i = 0; i < 2 * LAT; i++) begin
         step(idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL post_reset step %0d: got %h, expected %h", i, o, e);
         end
      end
   endtask

   task automatic test_count_wrap();
      logic [23:0] kcnt[4];
      exp_t        e, o;
      kcnt = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
      for (int i = 0; i < LAT; i++) begin
         step(idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL wrap_flush step %0d: got %h, expected %h", i, o, e);
         end
      end
      force dut.pixel_count_q = 24'hFFFFFD;
      force dut_nc.pixel_count_q = 24'hFFFFFD;
      #1;
      release dut.pixel_count_q;
      release dut_nc.pixel_count_q;
      model_cnt = 24'hFFFFFD;
      for (int k = 0; k < hq.size(); k++) begin
         hq[k].cnt  = 24'hFFFFFD;
         hq[k].cntn = 24'hFFFFFD;
      end
      for (int i = 0; i < 4 + LAT; i++) begin
         step((i < 4) ? rand_pix(1'b1, (i == 3), 1'b0) : idle, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("[TB] FAIL wrap_model step %0d: got %h, expected %h", i, o, e);
         end
         if (i >= LAT) begin
            vectors++;
            if ({o.v, o.cnt, o.cntn} !== {1'b1, kcnt[i-LAT], kcnt[i-LAT]}) begin
               miscompares++;
               $display("[TB] FAIL wrap_count %0d: got v=%b cnt=%h nc_cnt=%h, expected cnt=%h",
                        i - LAT, o.v, o.cnt, o.cntn, kcnt[i-LAT]);
            end
         end
      end
   endtask

   task automatic test_random(input int n);
      pix_t p;
      exp_t e, o;
      logic v;
      for (int i = 0; i < n + LAT; i++) begin
         if (i < n) begin
            v = ($urandom_range(0, 3) != 0);
            p = rand_pix(v, v && ($urandom_range(0, 499) == 0), v && ($urandom_range(0, 49) == 0));
            if ($urandom_range(0, 7) == 0) begin
               p.r = $urandom_range(0, 1) ? 8'd255 : 8'd0;
               p.g = $urandom_range(0, 1) ? 8'd255 : 8'd0;
               p.b = $urandom_range(0, 1) ? 8'd255 : 8'd0;
            end
         end else begin
            p = idle;
         end
         step(p, e, o);
         vectors++;
         if (o !== e) begin
            miscompares++;
            if (miscompares <= 20)
               $display("[TB] FAIL random step %0d: got %h, expected %h", i, o, e);
         end
      end
   endtask

   initial begin
      $display("[TB] rgb_to_ycbcr bench start");
      test_reset();
      test_known_colours();
      test_sideband();
      test_back_to_back();
      test_midstream_reset();
      test_count_wrap();
      test_random(30000);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
